// File: rtl/sc_fir_pkg.sv
// Shared defaults and types for the stochastic-computing FIR sequencer.
package sc_fir_pkg;

    localparam int unsigned SC_N          = 12;
    localparam int unsigned SC_STREAM_LEN = 4096;
    localparam int unsigned SC_NUM_STAGES = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        CAPTURE,
        OUT
    } seq_state_t;

    typedef logic [SC_N:0] sample_t;

endpackage

// File: rtl/sc_fir_sequencer_stream_counter.sv
// Stream cycle counter: synchronous clear, enable, saturates at LEN-1 with a terminal-count flag.
module sc_stream_counter #(
    parameter int unsigned W   = 13,
    parameter int unsigned LEN = 4096
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    localparam logic [W-1:0] LAST = W'(LEN - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == LAST);

endmodule

// File: rtl/sc_fir_sequencer.sv
// Per-sample sequencer for the SC FIR cascade: shift, start, run, capture per stage, then handshake out.
module sc_fir_sequencer
    import sc_fir_pkg::*;
#(
    parameter int unsigned N          = SC_N,
    parameter int unsigned STREAM_LEN = SC_STREAM_LEN,
    parameter int unsigned NUM_STAGES = SC_NUM_STAGES
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          abort,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N:0]                    in_data,
    output logic [N:0]                    sample_out,
    output logic [$clog2(NUM_STAGES)-1:0] stage_sel,
    output logic                          shift_en,
    output logic                          start,
    output logic                          run,
    output logic [N:0]                    cycle_cnt,
    output logic                          capture,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy
);

    localparam int unsigned SW = $clog2(NUM_STAGES);
    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

    seq_state_t    state_q, state_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [N:0]    sample_q, sample_d;
    logic          shift_en_q, start_q, run_q, capture_q, out_valid_q, in_ready_q, busy_q;
    logic          tc;

    // Clearing on the LOAD->START edge makes cycle_cnt read 0 in START and the first RUN cycle.
    sc_stream_counter #(
        .W   (N + 1),
        .LEN (STREAM_LEN)
    ) u_stream_counter (
        .clk_i   (clock),
        .rst_i   (reset),
        .clear_i ((state_q == LOAD) && !abort),
        .en_i    ((state_q == RUN) && !abort),
        .count_o (cycle_cnt),
        .tc_o    (tc)
    );

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        sample_d = sample_q;
        if (abort) begin
            state_d = IDLE;
            stage_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sample_d = in_data;
                        state_d  = LOAD;
                    end
                end
                LOAD:    state_d = START;
                START:   state_d = RUN;
                RUN: begin
                    if (tc) begin
                        state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (stage_q < LAST_STAGE) begin
                        stage_d = stage_q + 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        stage_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    stage_d = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they align with the state they describe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            stage_q     <= '0;
            sample_q    <= '0;
            shift_en_q  <= 1'b0;
            start_q     <= 1'b0;
            run_q       <= 1'b0;
            capture_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            sample_q    <= sample_d;
            shift_en_q  <= (state_d == LOAD);
            start_q     <= (state_d == START);
            run_q       <= (state_d == RUN);
            capture_q   <= (state_d == CAPTURE);
            out_valid_q <= (state_d == OUT);
            in_ready_q  <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign sample_out = sample_q;
    assign stage_sel  = stage_q;
    assign shift_en   = shift_en_q;
    assign start      = start_q;
    assign run        = run_q;
    assign capture    = capture_q;
    assign out_valid  = out_valid_q;
    assign in_ready   = in_ready_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sc_fir_sequencer.sv
// Directed + random bench for sc_fir_sequencer against a timeline model (offset since sample accept).
module tb_sc_fir_sequencer;

    localparam int N    = 4;
    localparam int SL   = 16;
    localparam int NS   = 3;
    localparam int PER  = SL + 3;
    localparam int OUTK = NS * PER + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [N:0] in_data = '0;
    logic in_ready, shift_en, start, run, capture, out_valid, busy;
    logic [N:0] sample_out, cycle_cnt;
    logic [1:0] stage_sel;

    logic d_abort = 1'b0, d_in_valid = 1'b0, d_out_ready = 1'b0;
    logic [12:0] d_in_data = '0;
    logic d_in_ready, d_shift_en, d_start, d_run, d_capture, d_out_valid, d_busy;
    logic [12:0] d_sample_out, d_cycle_cnt;
    logic [1:0] d_stage_sel;

    always #5 clk = ~clk;

    sc_fir_sequencer #(.N(N), .STREAM_LEN(SL), .NUM_STAGES(NS)) dut (
        .clock(clk), .reset(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .sample_out(sample_out), .stage_sel(stage_sel), .shift_en(shift_en),
        .start(start), .run(run), .cycle_cnt(cycle_cnt), .capture(capture),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    sc_fir_sequencer dut_def (
        .clock(clk), .reset(rst), .abort(d_abort), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_data(d_in_data), .sample_out(d_sample_out), .stage_sel(d_stage_sel), .shift_en(d_shift_en),
        .start(d_start), .run(d_run), .cycle_cnt(d_cycle_cnt), .capture(d_capture),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .busy(d_busy)
    );

    int errors = 0;
    int checks = 0;

    // Model: busy flag plus offset k of the current cycle from the accept cycle.
    bit         m_busy  = 0;
    int         m_k     = 0;
    bit         m_fresh = 1;
    logic [N:0] m_sample = '0;
    logic [N:0] m_cnt    = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic adv_model();
        int p;
        m_fresh = 0;
        if (abort) begin
            m_busy = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1;
                m_k = 1;
                m_sample = in_data;
            end
        end else if (m_k >= OUTK) begin
            if (out_ready) m_busy = 0;
        end else begin
            m_k++;
        end
        if (m_busy && m_k < OUTK) begin
            p = (m_k - 1) % PER;
            if (p == 1) m_cnt = '0;
            else if (p >= 2 && p < 2 + SL) m_cnt = (N+1)'(p - 2);
        end
    endtask

    task automatic check_outs(input string ctx);
        bit in_seq;
        int p, s;
        in_seq = m_busy && (m_k < OUTK);
        p = in_seq ? (m_k - 1) % PER : -1;
        s = in_seq ? (m_k - 1) / PER : 0;
        chk({ctx, ".shift_en"},  shift_en,  in_seq && p == 0);
        chk({ctx, ".start"},     start,     in_seq && p == 1);
        chk({ctx, ".run"},       run,       in_seq && p >= 2 && p < 2 + SL);
        chk({ctx, ".capture"},   capture,   in_seq && p == 2 + SL);
        chk({ctx, ".out_valid"}, out_valid, m_busy && m_k >= OUTK);
        chk({ctx, ".stage_sel"}, stage_sel, in_seq ? s : (m_busy ? NS - 1 : 0));
        chk({ctx, ".in_ready"},  in_ready,  !m_busy && !m_fresh);
        chk({ctx, ".busy"},      busy,      m_busy);
        chk({ctx, ".sample"},    sample_out, m_sample);
        chk({ctx, ".cycle_cnt"}, cycle_cnt, m_cnt);
    endtask

    task automatic step(input string ctx);
        adv_model();
        @(posedge clk);
        #1;
        check_outs(ctx);
    endtask

    task automatic run_sample(input string ctx, input logic [N:0] data, input int hold);
        int lat;
        in_valid = 1'b1;
        in_data = data;
        step(ctx);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            step(ctx);
            lat++;
        end
        chk({ctx, ".latency"}, lat, OUTK);
        for (int i = 0; i < hold; i++) step({ctx, ".hold"});
        out_ready = 1'b1;
        step({ctx, ".release"});
        out_ready = 1'b0;
        chk({ctx, ".stage_after_out"}, stage_sel, 0);
    endtask

    initial begin
        int changes, n, runs, peak;
        logic [N:0] prev;

        #2;
        check_outs("reset");
        @(posedge clk);
        #1;
        check_outs("reset_held");
        rst = 1'b0;
        step("idle0");

        // single sample, then out_ready held low for 10 cycles
        run_sample("t1", 5'h0A, 10);
        step("t2.idle");

        // continuous in_valid, out_ready high: one accept per OUTK+1 cycles
        in_valid = 1'b1;
        out_ready = 1'b1;
        changes = 0;
        prev = sample_out;
        for (int i = 0; i < 3 * (OUTK + 1); i++) begin
            in_data = (N+1)'(i + 1);
            step("t3");
            if (sample_out !== prev) changes++;
            prev = sample_out;
        end
        chk("t3.accepts", changes, 3);
        in_valid = 1'b0;
        n = 0;
        while (m_busy && n < 100) begin
            step("t3.drain");
            n++;
        end
        out_ready = 1'b0;
        chk("t3.drained", busy, 0);

        // abort during stage 1 RUN at cycle_cnt=7
        in_valid = 1'b1;
        in_data = 5'h13;
        step("t4");
        in_valid = 1'b0;
        while (m_k < PER + 10) step("t4");
        chk("t4.cnt_at_abort", cycle_cnt, 7);
        abort = 1'b1;
        step("t4.abort");
        abort = 1'b0;
        chk("t4.run_low", run, 0);
        chk("t4.in_ready", in_ready, 1);
        for (int i = 0; i < 30; i++) step("t4.after");

        // asynchronous reset during stage 2 RUN
        in_valid = 1'b1;
        in_data = 5'h1C;
        step("t5");
        in_valid = 1'b0;
        while (m_k < 2 * PER + 6) step("t5");
        #2;
        rst = 1'b1;
        #1;
        m_busy = 0;
        m_sample = '0;
        m_cnt = '0;
        m_fresh = 1;
        check_outs("t5.async");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_outs("t5.in_reset");
        end
        rst = 1'b0;
        step("t5.release");
        chk("t5.in_ready", in_ready, 1);
        run_sample("t5.rerun", 5'h07, 0);

        // randomized traffic
        for (int i = 0; i < 700; i++) begin
            abort     = ($urandom_range(0, 63) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = (N+1)'($urandom);
            out_ready = ($urandom_range(0, 3) == 0);
            step("rand");
        end
        abort = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;

        // default parameters: full-length streams
        d_in_valid = 1'b1;
        d_in_data = 13'h0ABC;
        n = 0;
        runs = 0;
        peak = 0;
        while (!d_out_valid && n < 13000) begin
            @(posedge clk);
            #1;
            d_in_valid = 1'b0;
            n++;
            if (d_run) runs++;
            if (int'(d_cycle_cnt) > peak) peak = int'(d_cycle_cnt);
        end
        chk("t6.latency", n, 3 * (4096 + 3) + 1);
        chk("t6.run_cycles", runs, 3 * 4096);
        chk("t6.cnt_peak", peak, 4095);
        chk("t6.sample", d_sample_out, 13'h0ABC);
        d_out_ready = 1'b1;
        @(posedge clk);
        #1;
        d_out_ready = 1'b0;
        chk("t6.idle", d_busy, 0);
        chk("t6.in_ready", d_in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
